// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared op encodings, FSM states and stride selects for iter_shifter
package shift_pkg;

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] STEP1 = 2'd0;
    localparam logic [1:0] STEP3 = 2'd1;
    localparam logic [1:0] STEP9 = 2'd2;

    // Largest stride that still fits in the remaining amount (base-3 digit retirement).
    function automatic logic [1:0] stride_sel(input logic [3:0] rem);
        if (rem >= 4'd9)      return STEP9;
        else if (rem >= 4'd3) return STEP3;
        else                  return STEP1;
    endfunction

    function automatic logic [3:0] stride_len(input logic [1:0] sel);
        case (sel)
            STEP9:   return 4'd9;
            STEP3:   return 4'd3;
            default: return 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-stride shift/rotate (1, 3 or 9 bits)
module shift_step
    import shift_pkg::*;
(
    input  logic [15:0] acc,
    input  logic [1:0]  op,
    input  logic [1:0]  sel,
    output logic [15:0] shifted
);

    always_comb begin
        shifted = acc;
        case (sel)
            STEP9: begin
                case (op)
                    OP_SRL:  shifted = {9'd0, acc[15:9]};
                    OP_SRA:  shifted = {{9{acc[15]}}, acc[15:9]};
                    OP_ROR:  shifted = {acc[8:0], acc[15:9]};
                    default: shifted = {acc[6:0], acc[15:7]};
                endcase
            end
            STEP3: begin
                case (op)
                    OP_SRL:  shifted = {3'd0, acc[15:3]};
                    OP_SRA:  shifted = {{3{acc[15]}}, acc[15:3]};
                    OP_ROR:  shifted = {acc[2:0], acc[15:3]};
                    default: shifted = {acc[12:0], acc[15:13]};
                endcase
            end
            default: begin
                case (op)
                    OP_SRL:  shifted = {1'b0, acc[15:1]};
                    OP_SRA:  shifted = {acc[15], acc[15:1]};
                    OP_ROR:  shifted = {acc[0], acc[15:1]};
                    default: shifted = {acc[14:0], acc[15]};
                endcase
            end
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - multi-cycle 16-bit SRL/SRA/ROR/ROL unit with start/done handshake
module iter_shifter
    import shift_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [3:0]  shamt,
    input  logic [15:0] value,
    output logic        busy,
    output logic        done,
    output logic [15:0] result
);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_acc;
    logic [3:0]  r_rem;
    logic [1:0]  r_op;

    logic [1:0]  w_sel;
    logic [3:0]  w_rem_next;
    logic [15:0] w_shifted;
    logic        w_accept;

    assign w_sel      = stride_sel(r_rem);
    assign w_rem_next = r_rem - stride_len(w_sel);
    assign w_accept   = start && (r_state != SHIFT);

    shift_step u_step (
        .acc     (r_acc),
        .op      (r_op),
        .sel     (w_sel),
        .shifted (w_shifted)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            SHIFT: begin
                if (w_rem_next == 4'd0) w_next = DONE;
            end
            default: begin
                if (start)                 w_next = (shamt != 4'd0) ? SHIFT : DONE;
                else if (r_state == DONE)  w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= 16'd0;
            r_rem   <= 4'd0;
            r_op    <= 2'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_acc <= value;
                r_rem <= shamt;
                r_op  <= op;
            end else if (r_state == SHIFT) begin
                r_acc <= w_shifted;
                r_rem <= w_rem_next;
            end
        end
    end

    assign busy   = (r_state == SHIFT);
    assign done   = (r_state == DONE);
    assign result = r_acc;

endmodule

// File: tb/tb_iter_shifter.sv
// tb/tb_iter_shifter.sv - randomized self-checking bench for iter_shifter
module tb_iter_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [3:0]  shamt;
    logic [15:0] value;
    logic        busy;
    logic        done;
    logic [15:0] result;

    int n_checks = 0;
    int n_errors = 0;

    iter_shifter dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .shamt  (shamt),
        .value  (value),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_shift(input logic [1:0] o, input logic [15:0] v, input int sh);
        logic [31:0] dbl;
        logic [31:0] tmp;
        dbl = {v, v};
        case (o)
            2'd0: return v >> sh;
            2'd1: return 16'($signed(v) >>> sh);
            2'd2: begin tmp = dbl >> sh; return tmp[15:0]; end
            default: begin tmp = dbl << sh; return tmp[31:16]; end
        endcase
    endfunction

    function automatic int ref_steps(input int sh);
        return sh / 9 + (sh % 9) / 3 + sh % 3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request for a single edge, then junk on the operand pins.
    task automatic launch(input logic [1:0] o, input logic [15:0] v, input logic [3:0] sh);
        start = 1'b1; op = o; value = v; shamt = sh;
        tick();
        start = 1'b0;
        op    = 2'($urandom);
        value = 16'($urandom);
        shamt = 4'($urandom);
    endtask

    task automatic wait_done(output int busy_cycles, output int cycles, output logic seen);
        busy_cycles = 0;
        cycles      = 0;
        seen        = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            cycles++;
            tick();
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] v, input logic [3:0] sh);
        int   bc, cy;
        logic seen;
        logic [15:0] exp;
        exp = ref_shift(o, v, int'(sh));
        launch(o, v, sh);
        wait_done(bc, cy, seen);
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " result"}, 32'(result), 32'(exp));
        check({tag, " busy_cycles"}, 32'(bc), 32'(ref_steps(int'(sh))));
        check({tag, " latency"}, 32'(cy), 32'(ref_steps(int'(sh))));
        tick();
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " hold"}, 32'(result), 32'(exp));
    endtask

    initial begin
        int   bc, cy;
        logic seen;
        logic [15:0] v;

        rst = 1'b1; start = 1'b0; op = 2'd0; shamt = 4'd0; value = 16'd0;
        tick();
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
        rst = 1'b0;
        tick();

        run_op("sra_8000_15", 2'd1, 16'h8000, 4'd15);
        check("sra_8000_15 value", 32'(result), 32'hFFFF);
        run_op("srl_f0f0_8", 2'd0, 16'hF0F0, 4'd8);
        check("srl_f0f0_8 value", 32'(result), 32'h00F0);
        run_op("rol_8001_14", 2'd3, 16'h8001, 4'd14);
        check("rol_8001_14 value", 32'(result), 32'h6000);
        run_op("ror_1234_0", 2'd2, 16'h1234, 4'd0);
        check("ror_1234_0 value", 32'(result), 32'h1234);

        // Back-to-back acceptance out of DONE.
        launch(2'd0, 16'hF0F0, 4'd8);
        wait_done(bc, cy, seen);
        check("b2b first done", 32'(seen), 32'd1);
        check("b2b first result", 32'(result), 32'h00F0);
        launch(2'd2, 16'h0001, 4'd1);
        check("b2b second busy", 32'(busy), 32'd1);
        tick();
        check("b2b second done", 32'(done), 32'd1);
        check("b2b second result", 32'(result), 32'h8000);
        tick();
        check("b2b idle", 32'(done | busy), 32'd0);

        // A start while busy must be ignored.
        launch(2'd0, 16'hFFFF, 4'd15);
        check("ignore busy", 32'(busy), 32'd1);
        start = 1'b1; op = 2'd3; value = 16'h1234; shamt = 4'd1;
        tick();
        start = 1'b0;
        wait_done(bc, cy, seen);
        check("ignore done", 32'(seen), 32'd1);
        check("ignore busy_cycles", 32'(bc + 1), 32'd3);
        check("ignore result", 32'(result), 32'h0001);
        tick();
        check("ignore after", 32'(done | busy), 32'd0);

        // Reset during the second SHIFT cycle.
        v = 16'($urandom) | 16'h8000;
        launch(2'd0, v, 4'd14);
        check("rst first shift", 32'(busy), 32'd1);
        tick();
        check("rst second shift", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", 32'(result), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        check("rst no done", 32'(seen), 32'd0);

        for (int o = 0; o < 4; o++) begin
            for (int sh = 0; sh < 16; sh++) begin
                run_op($sformatf("sweep op%0d sh%0d", o, sh), 2'(o), 16'($urandom), 4'(sh));
            end
        end

        for (int i = 0; i < 40; i++) begin
            run_op($sformatf("rand %0d", i), 2'($urandom), 16'($urandom), 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
